dcache_ctrl: RTL

DCACHE_CTRL -- requirements
Module: dcache_ctrl

---
 rtl/dcache_ctrl_if.sv | 27 ++
 rtl/dcache_ctrl.sv | 124 ++++++++++++
 2 files changed

// File: rtl/dcache_ctrl_if.sv
// CPU and block-memory signals of the data-cache controller, bundled for port use.
// The cache drives through the slave modport; the CPU/memory side uses master.
interface dcache_ctrl_if;
  logic         cpu_ren;
  logic         cpu_wen;
  logic [31:0]  cpu_addr;
  logic [31:0]  cpu_wdata;
  logic [31:0]  cpu_rdata;
  logic         cpu_stall;
  logic         mem_ren;
  logic         mem_wen;
  logic [27:0]  mem_block_address;
  logic [127:0] mem_din;
  logic [127:0] mem_dout;
  logic         mem_ready;
  logic         mem_done;

  modport slave (
    input  cpu_ren, cpu_wen, cpu_addr, cpu_wdata, mem_dout, mem_ready, mem_done,
    output cpu_rdata, cpu_stall, mem_ren, mem_wen, mem_block_address, mem_din
  );

  modport master (
    output cpu_ren, cpu_wen, cpu_addr, cpu_wdata, mem_dout, mem_ready, mem_done,
    input  cpu_rdata, cpu_stall, mem_ren, mem_wen, mem_block_address, mem_din
  );
endinterface

// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-back, write-allocate data cache controller with 4-word blocks.
// Memory strobes and addresses are registered; hits complete combinationally in idle.
module dcache_ctrl #(
  parameter int unsigned INDEX_BITS = 4
) (
  input logic          clock,
  input logic          reset,
  dcache_ctrl_if.slave bus
);

  localparam int unsigned Lines = 2 ** INDEX_BITS;
  localparam int unsigned TagW  = 28 - INDEX_BITS;

  typedef enum logic [1:0] {StIdle, StWriteback, StAllocate, StGap} state_e;

  state_e           r_state;
  logic [Lines-1:0] r_valid;
  logic [Lines-1:0] r_dirty;
  logic [TagW-1:0]  r_tag  [Lines];
  logic [127:0]     r_data [Lines];
  logic             r_mem_ren;
  logic             r_mem_wen;
  logic [27:0]      r_mem_addr;
  logic [127:0]     r_mem_din;

  logic [INDEX_BITS-1:0] w_index;
  logic [TagW-1:0]       w_tag;
  logic [1:0]            w_offset;
  logic                  w_req;
  logic                  w_hit;
  logic [127:0]          w_line;
  logic [31:0]           w_word;
  logic [127:0]          w_merged;
  logic                  w_wr_hit;
  logic                  w_fill;
  logic                  w_unused;

  assign w_index  = bus.cpu_addr[3+INDEX_BITS:4];
  assign w_tag    = bus.cpu_addr[31:4+INDEX_BITS];
  assign w_offset = bus.cpu_addr[3:2];
  assign w_unused = ^bus.cpu_addr[1:0];
  assign w_req    = bus.cpu_ren | bus.cpu_wen;
  assign w_hit    = r_valid[w_index] && (r_tag[w_index] == w_tag);
  assign w_line   = r_data[w_index];
  assign w_word   = w_line[{w_offset, 5'd0} +: 32];

  always_comb begin
    w_merged = w_line;
    w_merged[{w_offset, 5'd0} +: 32] = bus.cpu_wdata;
  end

  // Read+write together counts as a write, so cpu_wen alone decides the update.
  assign w_wr_hit = !reset && (r_state == StIdle) && bus.cpu_wen && w_hit;
  assign w_fill   = !reset && (r_state == StAllocate) && bus.mem_ready;

  // Tag and data arrays carry no reset; the valid bits guard them.
  always_ff @(posedge clock) begin
    if (w_fill) begin
      r_data[w_index] <= bus.mem_dout;
      r_tag[w_index]  <= w_tag;
    end else if (w_wr_hit) begin
      r_data[w_index] <= w_merged;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state    <= StIdle;
      r_valid    <= '0;
      r_dirty    <= '0;
      r_mem_ren  <= 1'b0;
      r_mem_wen  <= 1'b0;
      r_mem_addr <= '0;
      r_mem_din  <= '0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (w_req && !w_hit) begin
            if (r_valid[w_index] && r_dirty[w_index]) begin
              r_state    <= StWriteback;
              r_mem_wen  <= 1'b1;
              r_mem_addr <= {r_tag[w_index], w_index};
              r_mem_din  <= w_line;
            end else begin
              r_state    <= StAllocate;
              r_mem_ren  <= 1'b1;
              r_mem_addr <= bus.cpu_addr[31:4];
            end
          end else if (w_wr_hit) begin
            r_dirty[w_index] <= 1'b1;
          end
        end
        StWriteback: begin
          if (bus.mem_done) begin
            r_state   <= StGap;
            r_mem_wen <= 1'b0;
          end
        end
        StGap: begin
          r_state    <= StAllocate;
          r_mem_ren  <= 1'b1;
          r_mem_addr <= bus.cpu_addr[31:4];
        end
        StAllocate: begin
          if (bus.mem_ready) begin
            r_state          <= StIdle;
            r_mem_ren        <= 1'b0;
            r_valid[w_index] <= 1'b1;
            r_dirty[w_index] <= 1'b0;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign bus.mem_ren           = r_mem_ren;
  assign bus.mem_wen           = r_mem_wen;
  assign bus.mem_block_address = r_mem_addr;
  assign bus.mem_din           = r_mem_din;
  assign bus.cpu_stall         = (r_state != StIdle) || (w_req && !w_hit);
  assign bus.cpu_rdata         = ((r_state == StIdle) && bus.cpu_ren && w_hit) ? w_word : 32'd0;

endmodule
